// File: rtl/msk_aes_rcon_seq_if.sv
// Bus bundle for msk_aes_rcon_seq: control inputs, rcon sharing and status outputs.
// The rnd share input exists only when MSKAES_RCON_RANDOM_MASK_EN is defined.
interface msk_aes_rcon_seq_if #(
    parameter int unsigned d = 2
);
    logic             start;
    logic             mode_192;
    logic             mode_256;
    logic             inverse;
    logic             step;
    logic             mask_rcon;
    logic [8*d-1:0]   sh_rcon;
    logic             busy;
    logic             last;
    logic             done;
    logic [3:0]       step_idx;
`ifdef MSKAES_RCON_RANDOM_MASK_EN
    logic [8*(d-1)-1:0] rnd;
`endif

    // Driver side (key-schedule controller / testbench).
    modport master (
        output start, mode_192, mode_256, inverse, step, mask_rcon,
`ifdef MSKAES_RCON_RANDOM_MASK_EN
        output rnd,
`endif
        input  sh_rcon, busy, last, done, step_idx
    );

    // Sequencer side.
    modport slave (
        input  start, mode_192, mode_256, inverse, step, mask_rcon,
`ifdef MSKAES_RCON_RANDOM_MASK_EN
        input  rnd,
`endif
        output sh_rcon, busy, last, done, step_idx
    );
endinterface

// File: rtl/msk_aes_rcon_seq.sv
// Masked AES round-constant sequencer. Steps rcon forward (xtime) or backward
// (GF(2^8) halving) for AES-128/192/256 and presents it as a d-share, bit-sliced
// sharing: bit i of share s sits at sh_rcon[i*d + s].
// Optional feature macro: MSKAES_RCON_RANDOM_MASK_EN adds the rnd input and uses it
// for shares 1..d-1 (same bit-sliced layout with d-1 shares per bit).
module msk_aes_rcon_seq #(
    parameter int unsigned d = 2
) (
    input logic                  clk,
    input logic                  rst,
    msk_aes_rcon_seq_if.slave    bus
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e      state_q, state_d;
    logic [7:0]  rcon_q, rcon_d;
    logic [3:0]  idx_q, idx_d;
    logic        m192_q, m192_d;
    logic        m256_q, m256_d;
    logic        inv_q, inv_d;

    logic [3:0]  last_idx;
    logic [7:0]  rcon_init;
    logic [7:0]  rcon_fwd;
    logic [7:0]  rcon_bwd;
    logic [7:0]  v;

    // Index of the final rcon for the latched key size; mode_256 dominates.
    assign last_idx = m256_q ? 4'd6 : (m192_q ? 4'd7 : 4'd9);

    // Starting rcon: inverse runs begin at the last forward rcon of that key size.
    assign rcon_init = !bus.inverse ? 8'h01 :
                       bus.mode_256 ? 8'h40 :
                       bus.mode_192 ? 8'h80 : 8'h36;

    assign rcon_fwd = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
    assign rcon_bwd = {1'b0, rcon_q[7:1]} ^ (rcon_q[0] ? 8'h8d : 8'h00);

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            rcon_q  <= 8'h01;
            idx_q   <= 4'd0;
            m192_q  <= 1'b0;
            m256_q  <= 1'b0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rcon_q  <= rcon_d;
            idx_q   <= idx_d;
            m192_q  <= m192_d;
            m256_q  <= m256_d;
            inv_q   <= inv_d;
        end
    end

    // Next-state: start (any state) beats step; step only acts in RUN.
    always_comb begin
        state_d = state_q;
        rcon_d  = rcon_q;
        idx_d   = idx_q;
        m192_d  = m192_q;
        m256_d  = m256_q;
        inv_d   = inv_q;
        if (bus.start) begin
            state_d = StRun;
            rcon_d  = rcon_init;
            idx_d   = 4'd0;
            m192_d  = bus.mode_192;
            m256_d  = bus.mode_256;
            inv_d   = bus.inverse;
        end else if (bus.step && (state_q == StRun)) begin
            if (idx_q == last_idx) begin
                // Final step: hold rcon and index rather than wrapping.
                state_d = StDone;
            end else begin
                rcon_d = inv_q ? rcon_bwd : rcon_fwd;
                idx_d  = idx_q + 4'd1;
            end
        end
    end

    // Status outputs, purely from registers.
    always_comb begin
        bus.busy     = (state_q == StRun);
        bus.done     = (state_q == StDone);
        bus.last     = (state_q == StRun) && (idx_q == last_idx);
        bus.step_idx = idx_q;
    end

    // Unshared value and its bit-sliced sharing, combinational from mask_rcon.
    always_comb begin
        v           = ((state_q == StRun) && bus.mask_rcon) ? rcon_q : 8'h00;
        bus.sh_rcon = '0;
        for (int i = 0; i < 8; i++) begin
`ifdef MSKAES_RCON_RANDOM_MASK_EN
            bus.sh_rcon[i*d] = v[i] ^ (^bus.rnd[i*(d-1) +: (d-1)]);
            for (int s = 1; s < int'(d); s++) begin
                bus.sh_rcon[i*d + s] = bus.rnd[i*(d-1) + s - 1];
            end
`else
            bus.sh_rcon[i*d] = v[i];
`endif
        end
    end

endmodule
